// File: rtl/teclado_escaner.sv
// Matrix keypad scanner: drives one column low at a time, debounces the first closed
// row it finds and reports one code per press/release cycle.
module teclado_escaner #(
  parameter int unsigned FILAS           = 4,
  parameter int unsigned COLUMNAS        = 4,
  parameter int unsigned SCAN_CICLOS     = 1000,
  parameter int unsigned DEBOUNCE_CICLOS = 100000,
  localparam int unsigned CODIGO_W       = (FILAS * COLUMNAS > 1) ? $clog2(FILAS * COLUMNAS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [FILAS-1:0]    filas,
  output logic [COLUMNAS-1:0] columnas,
  output logic [CODIGO_W-1:0] codigo,
  output logic                valido,
  output logic                presionada
);

  localparam int unsigned FILA_W  = (FILAS > 1) ? $clog2(FILAS) : 1;
  localparam int unsigned COL_W   = $clog2(COLUMNAS);
  localparam int unsigned CNT_MAX = (SCAN_CICLOS > DEBOUNCE_CICLOS) ? SCAN_CICLOS : DEBOUNCE_CICLOS;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SCAN_FIN = CNT_W'(SCAN_CICLOS - 1);
  localparam logic [CNT_W-1:0] DEB_FIN  = CNT_W'(DEBOUNCE_CICLOS - 1);
  localparam logic [COL_W-1:0] COL_FIN  = COL_W'(COLUMNAS - 1);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HOLD,
    SOLTAR
  } estado_t;

  estado_t             estado;
  logic [FILAS-1:0]    s1;
  logic [FILAS-1:0]    fs;
  logic [COL_W-1:0]    col;
  logic [FILA_W-1:0]   fila;
  logic [CNT_W-1:0]    cnt;

  function automatic logic [COL_W-1:0] col_sig(input logic [COL_W-1:0] c);
    return (c == COL_FIN) ? '0 : c + COL_W'(1);
  endfunction

  function automatic logic [COLUMNAS-1:0] un_cero(input logic [COL_W-1:0] c);
    return ~(COLUMNAS'(1) << c);
  endfunction

  // Lowest-index row reading 0 wins when several keys share the driven column.
  function automatic logic [FILA_W-1:0] primera_baja(input logic [FILAS-1:0] f);
    logic [FILA_W-1:0] idx;
    idx = '0;
    for (int i = int'(FILAS) - 1; i >= 0; i--) begin
      if (!f[i]) idx = FILA_W'(i);
    end
    return idx;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '1;
      fs <= '1;
    end else begin
      s1 <= filas;
      fs <= s1;
    end
  end

  // cnt is the scan dwell in SCAN and the stability count in DEBOUNCE/SOLTAR.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado     <= SCAN;
      col        <= '0;
      fila       <= '0;
      cnt        <= '0;
      columnas   <= '1;
      codigo     <= '0;
      valido     <= 1'b0;
      presionada <= 1'b0;
    end else begin
      valido   <= 1'b0;
      columnas <= un_cero(col);
      case (estado)
        SCAN: begin
          if (cnt == SCAN_FIN) begin
            cnt <= '0;
            if (~&fs) begin
              fila   <= primera_baja(fs);
              estado <= DEBOUNCE;
            end else begin
              col      <= col_sig(col);
              columnas <= un_cero(col_sig(col));
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DEBOUNCE: begin
          if (fs[fila]) begin
            cnt    <= '0;
            estado <= SCAN;
          end else if (cnt == DEB_FIN) begin
            valido     <= 1'b1;
            codigo     <= CODIGO_W'(32'(fila) * COLUMNAS + 32'(col));
            presionada <= 1'b1;
            cnt        <= '0;
            estado     <= HOLD;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        HOLD: begin
          if (fs[fila]) begin
            cnt    <= '0;
            estado <= SOLTAR;
          end
        end
        SOLTAR: begin
          if (!fs[fila]) begin
            cnt    <= '0;
            estado <= HOLD;
          end else if (cnt == DEB_FIN) begin
            presionada <= 1'b0;
            col        <= col_sig(col);
            columnas   <= un_cero(col_sig(col));
            cnt        <= '0;
            estado     <= SCAN;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          cnt    <= '0;
          estado <= SCAN;
        end
      endcase
    end
  end

endmodule

// File: doc/teclado_escaner.md
TECLADO_ESCANER -- requirements
Module: teclado_escaner

Interface
REQ-001 Parameter FILAS, default 4: number of keypad rows sensed, minimum 1.
REQ-002 Parameter COLUMNAS, default 4: number of keypad columns driven, minimum 2.
REQ-003 Parameter SCAN_CICLOS, default 1000: clock cycles each column is driven before its rows are sampled, minimum 2.
REQ-004 Parameter DEBOUNCE_CICLOS, default 100000: consecutive stable cycles required to accept a press or a release, minimum 1.
REQ-005 Local parameter CODIGO_W SHALL equal max(1, $clog2(FILAS*COLUMNAS)).
REQ-006 clk  input  1  the single clock; all logic SHALL be on its rising edge.
REQ-007 rst  input  1  reset, synchronous and active-high.
REQ-008 filas  input  FILAS  row sense lines, active-low (0 = key closed in the driven column), asynchronous to clk.
REQ-009 columnas  output  COLUMNAS  column drive, one-cold (exactly one bit 0) outside reset.
REQ-010 codigo  output  CODIGO_W  code of the accepted key, equal to fila*COLUMNAS + columna.
REQ-011 valido  output  1  one-cycle pulse marking a newly accepted key.
REQ-012 presionada  output  1  level; 1 from acceptance until the accepted key's release is debounced.

Function
REQ-013 filas SHALL pass through a 2-flop synchronizer (flops reset to all ones); the FSM SHALL use only the synchronized value fs.
REQ-014 The FSM SHALL have four states: SCAN, DEBOUNCE, HOLD and SOLTAR.
REQ-015 SCAN: drive column col low; count dwell 0..SCAN_CICLOS-1; at dwell = SCAN_CICLOS-1, sample fs.
- If any bit is 0, capture the lowest-index 0 bit as fila, clear the counter and go to DEBOUNCE.
- Otherwise col increments (COLUMNAS-1 wraps to 0) and dwell restarts.
REQ-016 DEBOUNCE: col is held.
- Each cycle fs[fila]=0 increments the counter.
- fs[fila]=1 returns to SCAN on the same col with dwell cleared, and no output changes.
- When the counter reaches DEBOUNCE_CICLOS: valido=1 for exactly that one cycle, codigo=fila*COLUMNAS+col, presionada=1, go to HOLD.
REQ-017 HOLD: col is held; valido stays 0; fs[fila]=1 clears the counter and goes to SOLTAR; other rows are ignored.
REQ-018 SOLTAR: col is held.
- Each cycle fs[fila]=1 increments the counter.
- fs[fila]=0 returns to HOLD.
- At DEBOUNCE_CICLOS: presionada=0, col advances (with wrap), go to SCAN with dwell cleared.
REQ-019 codigo SHALL hold its last accepted value until the next acceptance.
REQ-020 Held keys SHALL NOT auto-repeat: one valido per press/release cycle regardless of hold length.
REQ-021 Simultaneous keys in the driven column: the lowest row index wins; keys in other columns are not seen until that column is scanned.
REQ-022 Counters SHALL saturate or stop at their terminal count, never wrap, for any DEBOUNCE_CICLOS up to 2^24.
REQ-023 A stable press SHALL produce valido within 2 + COLUMNAS*SCAN_CICLOS + DEBOUNCE_CICLOS + 2 cycles.

Reset
REQ-024 While rst=1 at a clock edge:
- columnas = all ones; codigo = 0; valido = 0; presionada = 0.
- State = SCAN, col = 0, all counters = 0, synchronizer = all ones.
REQ-025 On the first cycle after rst deasserts, columnas SHALL equal ~1 (column 0 driven).
REQ-026 Reset asserted in any state SHALL abort that state with no valido pulse.

Verification
REQ-027 Benches SHALL use FILAS=4, COLUMNAS=4, SCAN_CICLOS=4, DEBOUNCE_CICLOS=8 and a keypad model that drives filas from the pressed keys and columnas. They SHALL cover the following scenarios:
- Press row 2 / col 3, held stable: exactly one valido with codigo=11 within the REQ-023 bound; presionada=1; columnas holds 0111.
- Press row 1 / col 0 for 5 cycles, released, repeated 3 times: valido never asserts; scanning resumes.
- Rows 1 and 3 pressed in col 2 simultaneously: one valido, codigo=6.
- Key held 500 cycles, then released: exactly one valido. presionada falls 8-10 cycles after the release reaches fs. A re-press gives a second valido with the same codigo.
- rst pulsed mid-DEBOUNCE: no valido; columnas=1111 during reset, 1110 on the first cycle after.
- Release bounce of 3 cycles inside HOLD/SOLTAR: no extra valido; presionada stays 1.
